pwm_mask_sequencer: RTL and testbench
=====================================

PWM_MASK_SEQUENCER -- requirements
Module: pwm_mask_sequencer

Interface
REQ-001 SHALL have parameter MASK_W, default 32, mask width in bits (one bit per PWM output).
REQ-002 SHALL have parameter CNT_W, default 4, width of the blanking-period counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ce, input, 1, clock enable; while ce=0, all state holds except the fault path.
REQ-006 SHALL have port req_valid, input, 1, software mask-update request.
REQ-007 SHALL have port req_mask, input, MASK_W, requested new mask.
REQ-008 SHALL have port req_ready, output, 1, high when a request can be accepted.
REQ-009 SHALL have port period_tick, input, 1, one-cycle PWM carrier-boundary pulse.
REQ-010 SHALL have port blank_periods, input, CNT_W, number of carrier periods in the break-before-make interval.
REQ-011 SHALL have port fault, input, 1, level-sensitive trip request.
REQ-012 SHALL have port fault_clr, input, 1, one-cycle fault acknowledge.
REQ-013 SHALL have port mask_out, output, MASK_W, registered mask driven to the PWM mask stage.
REQ-014 SHALL have port busy, output, 1, high in states WAIT_EDGE and BLANK.
REQ-015 SHALL have port fault_active, output, 1, high in state FAULT.
REQ-016 SHALL have port apply_pulse, output, 1, one-cycle pulse on the cycle the final mask is written.

Function
REQ-017 SHALL implement states IDLE, WAIT_EDGE, BLANK and FAULT.
REQ-018 SHALL drive req_ready=1 only in IDLE with ce=1 and fault=0; a handshake is req_valid & req_ready.
REQ-019 SHALL, on a handshake in IDLE, capture req_mask into a pending register and enter WAIT_EDGE.
REQ-020 SHALL ignore a period_tick that coincides with the accepting handshake; the mask is applied no earlier than the next tick.
REQ-021 SHALL, in WAIT_EDGE on period_tick with blank_periods=0, load mask_out<=pending, pulse apply_pulse and enter IDLE.
REQ-022 SHALL, in WAIT_EDGE on period_tick with blank_periods>0, load mask_out<=mask_out & pending, load the counter with blank_periods and enter BLANK; this turns off leaving bits first and holds back arriving bits.
REQ-023 SHALL, in BLANK, decrement the counter on each period_tick; on a tick with counter=1, load mask_out<=pending, pulse apply_pulse and enter IDLE.
REQ-024 SHALL sample blank_periods only at the WAIT_EDGE to BLANK transition; later changes do not affect an update in progress.
REQ-025 SHALL update mask_out one cycle after the qualifying tick (registered, latency 1).
REQ-026 SHALL, when fault=1 in any state and regardless of ce, set mask_out<=0, discard pending, clear the counter and enter FAULT on the next edge.
REQ-027 SHALL stay in FAULT while fault=1; on fault_clr=1 with fault=0 it SHALL enter IDLE with mask_out=0.
REQ-028 SHALL give fault priority over tick, handshake and fault_clr when they occur in the same cycle.
REQ-029 SHALL keep mask_out unchanged in IDLE, so no tick alters it without an accepted request.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state=IDLE, mask_out=0, pending=0, counter=0 and apply_pulse=0; rst overrides fault and ce.
REQ-031 SHALL, when rst is asserted mid-update, abandon that update with no partial mask retained.

Structure
REQ-032 SHALL take the state enumeration and the MASK_W and CNT_W defaults from a shared package pwm_mask_pkg.
REQ-033 SHALL place the blanking counter (load, tick-decrement, terminal flag) in sub-module pwm_mask_blank_cnt.

Verification
REQ-034 SHALL cover: reset, then request 0x0000_00FF with blank=0, tick -> mask_out=0x0000_00FF one cycle after the tick, apply_pulse=1 for one cycle.
REQ-035 SHALL cover: mask 0x0000_000F, then request 0x0000_00F0 with blank=2 -> first tick gives 0x0, second tick holds 0x0, third tick gives 0x0000_00F0.
REQ-036 SHALL cover: handshake coincident with tick -> mask unchanged at that tick and applied at the following tick.
REQ-037 SHALL cover: fault=1 during BLANK -> mask_out=0 next cycle, fault_active=1, req_ready=0; fault_clr with fault=1 -> stays in FAULT; fault=0 then fault_clr -> IDLE, mask_out=0.
REQ-038 SHALL cover: ce=0 for 10 cycles with ticks during WAIT_EDGE -> no change; fault asserted with ce=0 -> mask_out=0 next cycle.
REQ-039 SHALL cover: rst mid-BLANK -> IDLE, mask_out=0; a new request 0xFFFF_FFFF with blank=0 and one tick -> mask_out=0xFFFF_FFFF.

Source files
------------

// File: rtl/pwm_mask_pkg.sv
// Shared types and default widths for the PWM mask sequencer.
package pwm_mask_pkg;

    localparam int unsigned MASK_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        BLANK     = 2'd2,
        FAULT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pwm_mask_sequencer_if.sv
// Software mask-update request channel (valid/ready with mask payload).
interface pwm_mask_sequencer_if
    import pwm_mask_pkg::*;
#(
    parameter int unsigned MASK_W = MASK_W_DEF
) ();

    logic              req_valid;
    logic [MASK_W-1:0] req_mask;
    logic              req_ready;

    modport master (output req_valid, output req_mask, input  req_ready);
    modport slave  (input  req_valid, input  req_mask, output req_ready);

endinterface

// File: rtl/pwm_mask_blank_cnt.sv
// Break-before-make period counter: load, decrement on carrier tick, flag last period.
module pwm_mask_blank_cnt
    import pwm_mask_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             term_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign term_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pwm_mask_sequencer.sv
// Applies software PWM mask updates on carrier boundaries with optional
// break-before-make blanking; a level fault forces the mask off immediately.
module pwm_mask_sequencer
    import pwm_mask_pkg::*;
#(
    parameter int unsigned MASK_W = MASK_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    pwm_mask_sequencer_if.slave  req,
    input  logic                 period_tick,
    input  logic [CNT_W-1:0]     blank_periods,
    input  logic                 fault,
    input  logic                 fault_clr,
    output logic [MASK_W-1:0]    mask_out,
    output logic                 busy,
    output logic                 fault_active,
    output logic                 apply_pulse
);

    seq_state_e        state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [MASK_W-1:0] pending_q, pending_d;
    logic              apply_q, apply_d;
    logic              cnt_clr, cnt_load, cnt_dec, cnt_term_c;

    pwm_mask_blank_cnt #(.CNT_W(CNT_W)) u_blank_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (blank_periods),
        .dec      (cnt_dec),
        .term_c   (cnt_term_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            apply_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            apply_q   <= apply_d;
        end
    end

    // Fault bypasses ce and every other request; everything else waits on ce.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        apply_d   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (fault) begin
            state_d   = FAULT;
            mask_d    = '0;
            pending_d = '0;
            cnt_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ce && req.req_valid) begin
                        pending_d = req.req_mask;
                        state_d   = WAIT_EDGE;
                    end
                end
                WAIT_EDGE: begin
                    if (ce && period_tick) begin
                        if (blank_periods == '0) begin
                            mask_d  = pending_q;
                            apply_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // Drop leaving bits now, hold arriving bits back.
                            mask_d   = mask_q & pending_q;
                            cnt_load = 1'b1;
                            state_d  = BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (ce && period_tick) begin
                        cnt_dec = 1'b1;
                        if (cnt_term_c) begin
                            mask_d  = pending_q;
                            apply_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        mask_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign req.req_ready = (state_q == IDLE) && ce && !fault;
    assign mask_out      = mask_q;
    assign apply_pulse   = apply_q;
    assign busy          = (state_q == WAIT_EDGE) || (state_q == BLANK);
    assign fault_active  = (state_q == FAULT);

endmodule

// File: tb/tb_pwm_mask_sequencer.sv
// Directed and randomized checks of pwm_mask_sequencer against a tick-counting reference model.
module tb_pwm_mask_sequencer;

    localparam int unsigned MASK_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, ce, period_tick, fault, fault_clr;
    logic [CNT_W-1:0]  blank_periods;
    logic [MASK_W-1:0] mask_out;
    logic              busy, fault_active, apply_pulse;

    int passed = 0;
    int total  = 0;

    pwm_mask_sequencer_if #(.MASK_W(MASK_W)) bus ();

    pwm_mask_sequencer #(.MASK_W(MASK_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .req           (bus.slave),
        .period_tick   (period_tick),
        .blank_periods (blank_periods),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .mask_out      (mask_out),
        .busy          (busy),
        .fault_active  (fault_active),
        .apply_pulse   (apply_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: an update is "accepted", then optionally "blanking"
    // with a count of carrier ticks still to go before the new mask lands.
    logic [31:0] m_mask, m_pend;
    bit          m_upd, m_blanking, m_fault, m_apply;
    int          m_left;

    function automatic bit model_ready();
        return !m_upd && !m_fault && ce && !fault;
    endfunction

    task automatic model_advance();
        m_apply = 1'b0;
        if (rst) begin
            m_mask = '0; m_pend = '0; m_upd = 0; m_blanking = 0; m_fault = 0; m_left = 0;
        end else if (fault) begin
            m_mask = '0; m_pend = '0; m_upd = 0; m_blanking = 0; m_fault = 1; m_left = 0;
        end else if (m_fault) begin
            if (fault_clr) begin
                m_fault = 0;
                m_mask  = '0;
            end
        end else if (ce) begin
            if (!m_upd) begin
                if (bus.req_valid) begin
                    m_upd  = 1;
                    m_pend = bus.req_mask;
                end
            end else if (period_tick) begin
                if (!m_blanking) begin
                    if (int'(blank_periods) == 0) begin
                        m_apply = 1'b1;
                    end else begin
                        m_mask     = m_mask & m_pend;
                        m_left     = int'(blank_periods);
                        m_blanking = 1;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_apply = 1'b1;
                end
                if (m_apply) begin
                    m_mask     = m_pend;
                    m_upd      = 0;
                    m_blanking = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic quiet();
        rst = 0; ce = 1; period_tick = 0; fault = 0; fault_clr = 0;
        bus.req_valid = 0;
    endtask

    // One clock: check ready against current inputs, then registered outputs after the edge.
    task automatic step();
        #1;
        check("req_ready", 32'(bus.req_ready), 32'(model_ready()));
        model_advance();
        @(posedge clk);
        #1;
        check("mask_out", mask_out, m_mask);
        check("apply_pulse", 32'(apply_pulse), 32'(m_apply));
        check("busy", 32'(busy), 32'(m_upd));
        check("fault_active", 32'(fault_active), 32'(m_fault));
    endtask

    task automatic request(input logic [31:0] mask, input logic [CNT_W-1:0] blank);
        bus.req_valid = 1; bus.req_mask = mask; blank_periods = blank;
        step();
        bus.req_valid = 0;
    endtask

    task automatic tick();
        period_tick = 1;
        step();
        period_tick = 0;
    endtask

    initial begin
        m_mask = '0; m_pend = '0; m_upd = 0; m_blanking = 0; m_fault = 0; m_left = 0; m_apply = 0;
        quiet();
        bus.req_mask = '0; blank_periods = '0;
        @(posedge clk); #1;

        // Reset state
        rst = 1; step(); step();
        check("reset_mask", mask_out, 32'h0);
        quiet();

        // Plain update, no blanking
        request(32'h0000_00FF, 4'd0);
        step();
        tick();
        check("d034_mask", mask_out, 32'h0000_00FF);
        check("d034_apply", 32'(apply_pulse), 32'd1);
        step();
        check("d034_apply_off", 32'(apply_pulse), 32'd0);

        // Break-before-make with two blanking periods
        request(32'h0000_000F, 4'd0); tick();
        request(32'h0000_00F0, 4'd2);
        tick();
        check("d035_t1", mask_out, 32'h0);
        step();
        tick();
        check("d035_t2", mask_out, 32'h0);
        tick();
        check("d035_t3", mask_out, 32'h0000_00F0);

        // Handshake coincident with tick is not applied on that tick
        period_tick = 1;
        request(32'h0000_003C, 4'd0);
        period_tick = 0;
        check("d036_hold", mask_out, 32'h0000_00F0);
        tick();
        check("d036_apply", mask_out, 32'h0000_003C);

        // Fault during BLANK, clear blocked while fault still high
        request(32'h0000_0055, 4'd3);
        tick(); tick();
        fault = 1; step();
        check("d037_mask", mask_out, 32'h0);
        check("d037_fact", 32'(fault_active), 32'd1);
        fault_clr = 1; step();
        check("d037_stuck", 32'(fault_active), 32'd1);
        fault = 0; fault_clr = 0; step();
        fault_clr = 1; step();
        fault_clr = 0;
        check("d037_clr", 32'(fault_active), 32'd0);
        check("d037_clr_mask", mask_out, 32'h0);

        // Clock enable low freezes an update; fault still acts
        request(32'h0000_00A5, 4'd0); tick();
        request(32'h0000_005A, 4'd0);
        ce = 0; period_tick = 1;
        for (int i = 0; i < 10; i++) step();
        period_tick = 0;
        check("d038_frozen", mask_out, 32'h0000_00A5);
        fault = 1; step();
        check("d038_fault", mask_out, 32'h0);
        fault = 0; ce = 1; fault_clr = 1; step();
        fault_clr = 0;

        // Reset mid-blank, then full-on update
        request(32'h0000_F0F0, 4'd4);
        tick(); tick();
        rst = 1; step();
        rst = 0;
        check("d039_rst", mask_out, 32'h0);
        check("d039_busy", 32'(busy), 32'd0);
        request(32'hFFFF_FFFF, 4'd0);
        tick();
        check("d039_full", mask_out, 32'hFFFF_FFFF);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(99) == 0);
            ce            = ($urandom_range(99) < 85);
            fault         = ($urandom_range(99) < 3);
            fault_clr     = ($urandom_range(99) < 20);
            period_tick   = ($urandom_range(99) < 30);
            blank_periods = CNT_W'($urandom_range(3));
            bus.req_valid = ($urandom_range(1) == 1);
            bus.req_mask  = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
